// File: rtl/ccff_chain_loader.sv
// Streams bitstream words LSB-first into a ccff configuration chain with a gated shift enable.
// Optional tail parity checker is enabled by defining CCFF_TAIL_PARITY_EN.
module ccff_chain_loader #(
    parameter int CHAIN_LENGTH = 20,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                                prog_clk,
    input  logic                                pReset_n,
    input  logic                                start,
    input  logic                                abort,
    input  logic [WORD_WIDTH-1:0]               in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic                                ccff_head,
    output logic                                ccff_shift_en,
    input  logic                                ccff_tail,
    output logic                                busy,
    output logic                                done,
    output logic [$clog2(CHAIN_LENGTH+1)-1:0]   bit_count
`ifdef CCFF_TAIL_PARITY_EN
    ,
    output logic                                tail_parity
`endif
);

    localparam int BC_W         = $clog2(CHAIN_LENGTH + 1);
    localparam int RC_W         = $clog2(WORD_WIDTH + 1);
    localparam int WORDS_NEEDED = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int WC_W         = $clog2(WORDS_NEEDED + 1);

    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(CHAIN_LENGTH - 1);
    localparam logic [RC_W-1:0] FULL_WORD = RC_W'(WORD_WIDTH);
    localparam logic [RC_W-1:0] ONE_LEFT  = RC_W'(1);
    localparam logic [WC_W-1:0] WORDS_MAX = WC_W'(WORDS_NEEDED);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]            state;
    logic [WORD_WIDTH-1:0] word_reg;
    logic [RC_W-1:0]       rem_bits;
    logic [WC_W-1:0]       words_taken;
    logic                  head_hold;
    logic                  in_shift;
    logic                  has_bit;
    logic                  last_bit;
    logic                  take_word;

    assign in_shift      = (state == S_SHIFT);
    assign has_bit       = (rem_bits != '0);
    assign ccff_shift_en = in_shift && has_bit && !abort;
    assign last_bit      = ccff_shift_en && (bit_count == LAST_BIT);

    // A new word may land while the last bit of the current one leaves, giving bubble-free streaming.
    assign in_ready  = in_shift && !abort && (words_taken != WORDS_MAX) &&
                       (!has_bit || ((rem_bits == ONE_LEFT) && ccff_shift_en));
    assign take_word = in_valid && in_ready;

    assign ccff_head = ccff_shift_en ? word_reg[0] : head_hold;
    assign busy      = in_shift;
    assign done      = (state == S_DONE);

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state       <= S_IDLE;
            word_reg    <= '0;
            rem_bits    <= '0;
            words_taken <= '0;
            head_hold   <= 1'b0;
            bit_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state       <= S_SHIFT;
                        bit_count   <= '0;
                        words_taken <= '0;
                        rem_bits    <= '0;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        rem_bits <= '0;
                    end else begin
                        if (ccff_shift_en) begin
                            head_hold <= word_reg[0];
                            word_reg  <= word_reg >> 1;
                            rem_bits  <= rem_bits - 1'b1;
                            bit_count <= bit_count + 1'b1;
                        end
                        if (take_word) begin
                            word_reg    <= in_data;
                            rem_bits    <= FULL_WORD;
                            words_taken <= words_taken + 1'b1;
                        end
                        // Bits left in the final word past the chain end are dropped.
                        if (last_bit) begin
                            state    <= S_DONE;
                            rem_bits <= '0;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CCFF_TAIL_PARITY_EN
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            tail_parity <= 1'b0;
        end else if ((state == S_IDLE) && start && !abort) begin
            tail_parity <= 1'b0;
        end else if (ccff_shift_en) begin
            tail_parity <= tail_parity ^ ccff_tail;
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: expected head bits and done events are queued by the
// driver from the load's words; an independent monitor checks them as the DUT shifts.
module tb_ccff_chain_loader;

    localparam int CL = 20;
    localparam int WW = 8;

    logic          prog_clk  = 1'b0;
    logic          pReset_n  = 1'b0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          ccff_tail = 1'b0;
    logic [WW-1:0] in_data   = '0;
    logic          in_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          busy;
    logic          done;
    logic [4:0]    bit_count;
`ifdef CCFF_TAIL_PARITY_EN
    logic          tail_parity;
`endif

    int errors = 0;
    int checks = 0;
    bit exp_head[$];
    int exp_done[$];

    ccff_chain_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW)) dut (
        .prog_clk      (prog_clk),
        .pReset_n      (pReset_n),
        .start         (start),
        .abort         (abort),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .bit_count     (bit_count)
`ifdef CCFF_TAIL_PARITY_EN
        ,
        .tail_parity   (tail_parity)
`endif
    );

    always #5 prog_clk = ~prog_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_head"},     ccff_head,     0);
        checkOutput({tag, "_shift_en"}, ccff_shift_en, 0);
        checkOutput({tag, "_in_ready"}, in_ready,      0);
        checkOutput({tag, "_busy"},     busy,          0);
        checkOutput({tag, "_done"},     done,          0);
        checkOutput({tag, "_bit_count"}, bit_count,    0);
    endtask

    // Monitor: compares every shifted bit, starve hold behaviour and each done pulse.
    initial begin
        bit last_head = 0;
        bit seen = 0;
        bit par = 0;
        int scnt = 0;
        int starves = 0;
        forever begin
            @(negedge prog_clk);
            if (!pReset_n) begin
                seen = 0; scnt = 0; starves = 0; par = 0;
                continue;
            end
            if (ccff_shift_en) begin
                if (exp_head.size() == 0) checkOutput("unexpected_shift", 1, 0);
                else checkOutput("ccff_head", ccff_head, exp_head.pop_front());
                last_head = ccff_head;
                par ^= ccff_tail;
                scnt++;
                seen = 1;
            end else if (busy && seen) begin
                starves++;
                checkOutput("head_hold", ccff_head, last_head);
            end
            if (in_ready && !busy) checkOutput("ready_outside_shift", in_ready, 0);
            if (done) begin
                if (exp_done.size() == 0) begin
                    checkOutput("unexpected_done", done, 0);
                end else begin
                    int st;
                    st = exp_done.pop_front();
                    checkOutput("shift_cycles", scnt, CL);
                    checkOutput("done_bit_count", bit_count, CL);
                    if (st >= 0) checkOutput("starve_cycles", starves, st);
`ifdef CCFF_TAIL_PARITY_EN
                    checkOutput("tail_parity", tail_parity, par);
`endif
                end
            end
            if (!busy) begin
                seen = 0; scnt = 0; starves = 0;
                if (!done) par = 0;
            end
        end
    end

    // One load: gap = in_valid-low cycles while the DUT wants word 2; abort_at/reset_at cut the load after N bits.
    task automatic applyStimulus(input logic [WW-1:0] w0, input logic [WW-1:0] w1, input logic [WW-1:0] w2,
                                 input int gap, input bit rnd_valid, input bit storm,
                                 input int abort_at, input int reset_at);
        logic [WW-1:0] words[3];
        int nexp, widx, shifts, cyc, gapcnt;
        bit fin, gapping, sh, acc, dn;
        words = '{w0, w1, w2};
        nexp = CL;
        if (abort_at > 0) nexp = abort_at;
        if (reset_at > 0) nexp = reset_at;
        for (int i = 0; i < nexp; i++) exp_head.push_back(words[i / WW][i % WW]);
        if (abort_at == 0 && reset_at == 0) exp_done.push_back(rnd_valid ? -1 : gap);

        @(posedge prog_clk); #1;
        start = 1'b1;
        @(posedge prog_clk); #1;
        if (!storm) start = 1'b0;
        in_valid = 1'b1;
        in_data  = words[0];
        widx = 0; shifts = 0; cyc = 0; gapcnt = 0; fin = 0; gapping = 0;
        while (!fin && cyc < 200) begin
            @(negedge prog_clk);
            cyc++;
            sh  = ccff_shift_en;
            acc = in_valid && in_ready;
            dn  = done;
            if (sh) shifts++;
            if (acc) widx++;
            if (acc && widx == 1 && gap > 0) gapping = 1;
            if (gapping && in_ready && !in_valid) gapcnt++;
            @(posedge prog_clk); #1;
            ccff_tail = 1'($urandom);
            if (reset_at > 0 && sh && shifts == reset_at) begin
                pReset_n = 1'b0;
                #1;
                checkAllZero("mid_reset");
                in_valid = 1'b0;
                @(posedge prog_clk); #1;
                pReset_n = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge prog_clk);
                    checkOutput("post_reset_ready", in_ready, 0);
                    checkOutput("post_reset_busy", busy, 0);
                end
                fin = 1;
            end else if (abort_at > 0 && sh && shifts == abort_at) begin
                abort = 1'b1;
                #1;
                checkOutput("abort_shift_en", ccff_shift_en, 0);
                @(posedge prog_clk); #1;
                abort = 1'b0;
                in_valid = 1'b0;
                @(negedge prog_clk);
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_bit_count", bit_count, abort_at);
                fin = 1;
            end else if (dn) begin
                start = 1'b0;
                in_valid = 1'b0;
                fin = 1;
            end else begin
                if (widx >= 3) in_valid = 1'b0;
                else if (gapping && gapcnt < gap) in_valid = 1'b0;
                else if (in_valid && !acc) in_valid = 1'b1;
                else in_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (gapping && gapcnt >= gap) gapping = 0;
                in_data = (widx < 3) ? words[widx] : '0;
            end
        end
        if (!fin) checkOutput("load_timeout", 1, 0);
        checkOutput("head_queue_drained", exp_head.size(), 0);
        exp_head.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkAllZero("reset");
        @(posedge prog_clk); #1;
        pReset_n = 1'b1;
        applyStimulus(8'hA5, 8'h3C, 8'h0F, 0, 0, 0, 0, 0);
        applyStimulus(8'hA5, 8'h3C, 8'h0F, 3, 0, 0, 0, 0);
        applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 5, 0);
        applyStimulus(8'h5A, 8'hC3, 8'hF0, 0, 0, 0, 0, 0);
        applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 0, 12);
        applyStimulus(8'h96, 8'h69, 8'hE1, 0, 1, 1, 0, 0);
        @(negedge prog_clk);
        checkOutput("storm_idle_busy", busy, 0);
        for (int i = 0; i < 8; i++)
            applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 0, 1, 1'($urandom), 0, 0);
        repeat (4) @(negedge prog_clk);
        checkOutput("done_queue_drained", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
